// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared constants and types for the generic inter-stage pipeline latch
// (pipe_stage_gen):
//   - MAX_DEPTH                            : deepest legal latch chain
//   - EX_CTRL_LSB / M_CTRL_LSB / WB_CTRL_LSB: ID/EX control field offsets
//   - CH_BUS_A / CH_BUS_B / CH_IMMED / CH_INSTRUC: data channel indices
//   - stage_act_e                          : per-edge action shared by all stages
// No ports (package).
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned MAX_DEPTH = 4;

    // ID/EX control word layout: {WB[7:6], M[5:4], EX[3:0]}
    localparam int unsigned EX_CTRL_LSB = 0;
    localparam int unsigned M_CTRL_LSB  = 4;
    localparam int unsigned WB_CTRL_LSB = 6;

    // Channel k sits at data[k*DATA_W +: DATA_W]
    localparam int unsigned CH_BUS_A   = 0;
    localparam int unsigned CH_BUS_B   = 1;
    localparam int unsigned CH_IMMED   = 2;
    localparam int unsigned CH_INSTRUC = 3;

    // What every stage does on the coming edge
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_CLEAR = 2'd1,
        ACT_LOAD  = 2'd2
    } stage_act_e;

    // True when a depth value can be built
    function automatic bit depth_legal(input int unsigned depth);
        return (depth >= 1) && (depth <= MAX_DEPTH);
    endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// ----------------------------------------------------------------------------
// pipe_stage_cell
// One pipeline latch: valid bit, control field and data bus.
// Priority per edge: clear > hold > load; with none asserted it keeps its value.
// Ports:
//   clock, reset        : rising-edge clock, async active-high reset
//   hold, clear, load   : stage action for this edge
//   valid_d/ctrl_d/data_d : value captured on load
//   valid_q/ctrl_q/data_q : registered stage contents
// ----------------------------------------------------------------------------
module pipe_stage_cell #(
    parameter int unsigned CTRL_W    = 8,
    parameter int unsigned DATA_BITS = 128
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 hold,
    input  logic                 clear,
    input  logic                 load,
    input  logic                 valid_d,
    input  logic [CTRL_W-1:0]    ctrl_d,
    input  logic [DATA_BITS-1:0] data_d,
    output logic                 valid_q,
    output logic [CTRL_W-1:0]    ctrl_q,
    output logic [DATA_BITS-1:0] data_q
);

    // Stage register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (!hold && load) begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pipe_stage_gen.sv
// ----------------------------------------------------------------------------
// pipe_stage_gen
// Parametrised inter-stage pipeline latch (IF/ID .. MEM/WB class): carries a
// valid bit, a control field and NUM_CH data buses through DEPTH stages, with
// global enable, stall, entry bubble and full flush.
// Optional statistics counters: define PIPE_STAGE_STATS_EN to build the
// saturating stall/bubble counters; otherwise both count ports read 0.
// Ports:
//   clock, reset          : rising-edge clock, async active-high reset
//   enable                : 0 freezes every register including counters
//   stall                 : hold all stages
//   bubble                : insert an empty slot at stage 0
//   flush                 : empty every stage (beats stall and bubble)
//   valid_in/ctrl_in/data_in    : entry instruction
//   valid_out/ctrl_out/data_out : last-stage contents (registered)
//   stall_cnt, bubble_cnt : saturating statistics
// ----------------------------------------------------------------------------
module pipe_stage_gen
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W              = 32,
    parameter int unsigned NUM_CH              = 4,
    parameter int unsigned CTRL_W              = 8,
    parameter int unsigned DEPTH               = 1,
    parameter bit          ZERO_CTRL_ON_BUBBLE = 1'b1,
    parameter int unsigned CNT_W               = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     stall,
    input  logic                     bubble,
    input  logic                     flush,
    input  logic                     valid_in,
    input  logic [CTRL_W-1:0]        ctrl_in,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    output logic                     valid_out,
    output logic [CTRL_W-1:0]        ctrl_out,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         bubble_cnt
);

    localparam int unsigned BUS_W = NUM_CH * DATA_W;

    // Reject unsupported depths at elaboration
    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $error("pipe_stage_gen: DEPTH=%0d outside 1..%0d", DEPTH, MAX_DEPTH);
    end

    // Priority decode: enable, then flush, then stall, else advance
    stage_act_e act_c;
    always_comb begin
        act_c = ACT_LOAD;
        if (!enable) begin
            act_c = ACT_HOLD;
        end else if (flush) begin
            act_c = ACT_CLEAR;
        end else if (stall) begin
            act_c = ACT_HOLD;
        end
    end

    logic hold_c, clear_c, load_c;
    assign hold_c  = (act_c == ACT_HOLD);
    assign clear_c = (act_c == ACT_CLEAR);
    assign load_c  = (act_c == ACT_LOAD);

    // Stage-0 source: an explicit bubble and an invalid entry look the same
    logic              entry_empty_c;
    logic              entry_valid_c;
    logic [CTRL_W-1:0] entry_ctrl_c;
    logic [BUS_W-1:0]  entry_data_c;
    always_comb begin
        entry_empty_c = bubble || !valid_in;
        entry_valid_c = !entry_empty_c;
        entry_ctrl_c  = ctrl_in;
        entry_data_c  = data_in;
        if (entry_empty_c) begin
            entry_data_c = '0;
            if (ZERO_CTRL_ON_BUBBLE) begin
                entry_ctrl_c = '0;
            end
        end
    end

    logic              stage_valid [DEPTH];
    logic [CTRL_W-1:0] stage_ctrl  [DEPTH];
    logic [BUS_W-1:0]  stage_data  [DEPTH];

    // Latch chain: stage 0 fed from the entry mux, stage i from stage i-1
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic              src_valid;
        logic [CTRL_W-1:0] src_ctrl;
        logic [BUS_W-1:0]  src_data;

        if (i == 0) begin : g_head
            assign src_valid = entry_valid_c;
            assign src_ctrl  = entry_ctrl_c;
            assign src_data  = entry_data_c;
        end else begin : g_tail
            assign src_valid = stage_valid[i-1];
            assign src_ctrl  = stage_ctrl[i-1];
            assign src_data  = stage_data[i-1];
        end

        pipe_stage_cell #(
            .CTRL_W    (CTRL_W),
            .DATA_BITS (BUS_W)
        ) u_cell (
            .clock   (clock),
            .reset   (reset),
            .hold    (hold_c),
            .clear   (clear_c),
            .load    (load_c),
            .valid_d (src_valid),
            .ctrl_d  (src_ctrl),
            .data_d  (src_data),
            .valid_q (stage_valid[i]),
            .ctrl_q  (stage_ctrl[i]),
            .data_q  (stage_data[i])
        );
    end

    assign valid_out = stage_valid[DEPTH-1];
    assign ctrl_out  = stage_ctrl[DEPTH-1];
    assign data_out  = stage_data[DEPTH-1];

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // A stall alongside a bubble counts only as a stall
    logic stall_inc_c, bubble_inc_c;
    assign stall_inc_c  = enable && stall && !flush;
    assign bubble_inc_c = enable && bubble && !stall && !flush;

    // Saturating statistics counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_inc_c && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (bubble_inc_c && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_gen.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_gen
// Five pipe_stage_gen instances share one stimulus stream:
//   u0 DEPTH=1, u1 DEPTH=2, u2 DEPTH=2 (control passes on bubble),
//   u3 DEPTH=3, u4 DEPTH=3 with CNT_W=2.
// A per-instance queue scoreboard tracks expected stage contents; a vector
// table and hand-written sequences add fixed expected values.
// ----------------------------------------------------------------------------
module tb_pipe_stage_gen;
    import pipe_pkg::*;

    localparam int NU = 5;

`ifdef PIPE_STAGE_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    typedef struct packed {
        logic         valid;
        logic [7:0]   ctrl;
        logic [127:0] data;
    } stage_t;

    typedef struct {
        logic        en, st, bu, fl, vi;
        logic [7:0]  ctrl;
        logic [31:0] ch3;
        logic        ev;
        logic [7:0]  ectrl;
        logic [31:0] ech3;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable, stall, bubble, flush, valid_in;
    logic [7:0]   ctrl_in;
    logic [127:0] data_in;

    logic         o_valid [NU];
    logic [7:0]   o_ctrl  [NU];
    logic [127:0] o_data  [NU];
    logic [15:0]  o_scnt  [NU];
    logic [15:0]  o_bcnt  [NU];
    logic [1:0]   sat_scnt, sat_bcnt;

    int checks   = 0;
    int failures = 0;

    stage_t      sb     [NU][$];
    int unsigned m_scnt [NU];
    int unsigned m_bcnt [NU];
    vec_t        vt     [12];

    always #5 clock = ~clock;

    pipe_stage_gen #(.DEPTH(1)) u0 (
        .clock(clock), .reset(reset), .enable(enable), .stall(stall), .bubble(bubble),
        .flush(flush), .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in),
        .valid_out(o_valid[0]), .ctrl_out(o_ctrl[0]), .data_out(o_data[0]),
        .stall_cnt(o_scnt[0]), .bubble_cnt(o_bcnt[0]));

    pipe_stage_gen #(.DEPTH(2), .ZERO_CTRL_ON_BUBBLE(1'b1)) u1 (
        .clock(clock), .reset(reset), .enable(enable), .stall(stall), .bubble(bubble),
        .flush(flush), .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in),
        .valid_out(o_valid[1]), .ctrl_out(o_ctrl[1]), .data_out(o_data[1]),
        .stall_cnt(o_scnt[1]), .bubble_cnt(o_bcnt[1]));

    pipe_stage_gen #(.DEPTH(2), .ZERO_CTRL_ON_BUBBLE(1'b0)) u2 (
        .clock(clock), .reset(reset), .enable(enable), .stall(stall), .bubble(bubble),
        .flush(flush), .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in),
        .valid_out(o_valid[2]), .ctrl_out(o_ctrl[2]), .data_out(o_data[2]),
        .stall_cnt(o_scnt[2]), .bubble_cnt(o_bcnt[2]));

    pipe_stage_gen #(.DEPTH(3)) u3 (
        .clock(clock), .reset(reset), .enable(enable), .stall(stall), .bubble(bubble),
        .flush(flush), .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in),
        .valid_out(o_valid[3]), .ctrl_out(o_ctrl[3]), .data_out(o_data[3]),
        .stall_cnt(o_scnt[3]), .bubble_cnt(o_bcnt[3]));

    pipe_stage_gen #(.DEPTH(3), .CNT_W(2)) u4 (
        .clock(clock), .reset(reset), .enable(enable), .stall(stall), .bubble(bubble),
        .flush(flush), .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in),
        .valid_out(o_valid[4]), .ctrl_out(o_ctrl[4]), .data_out(o_data[4]),
        .stall_cnt(sat_scnt), .bubble_cnt(sat_bcnt));

    assign o_scnt[4] = 16'(sat_scnt);
    assign o_bcnt[4] = 16'(sat_bcnt);

    function automatic int unit_depth(input int u);
        case (u)
            0:       return 1;
            1, 2:    return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit unit_zero_ctrl(input int u);
        return u != 2;
    endfunction

    function automatic int unsigned unit_cnt_max(input int u);
        return (u == 4) ? 32'd3 : 32'd65535;
    endfunction

    function automatic logic [15:0] exp_cnt(input int unsigned n);
        return STATS_ON ? 16'(n) : 16'd0;
    endfunction

    function automatic logic [127:0] word(input int unsigned w);
        return {32'(w) + 32'h3000_0000, 32'(w) + 32'h2000_0000,
                32'(w) + 32'h1000_0000, 32'(w)};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < NU; u++) begin
            sb[u].delete();
            for (int i = 0; i < unit_depth(u); i++) sb[u].push_back('0);
            m_scnt[u] = 0;
            m_bcnt[u] = 0;
        end
    endtask

    // Expected effect of the coming edge, from the current inputs
    task automatic model_step();
        if (!enable) return;
        for (int u = 0; u < NU; u++) begin
            if (flush) begin
                for (int i = 0; i < sb[u].size(); i++) sb[u][i] = '0;
            end else if (!stall) begin
                stage_t e;
                e.valid = valid_in && !bubble;
                e.ctrl  = ((bubble || !valid_in) && unit_zero_ctrl(u)) ? 8'h00 : ctrl_in;
                e.data  = (bubble || !valid_in) ? 128'd0 : data_in;
                sb[u].push_front(e);
                void'(sb[u].pop_back());
            end
            if (STATS_ON && stall && !flush && m_scnt[u] < unit_cnt_max(u)) m_scnt[u]++;
            if (STATS_ON && bubble && !stall && !flush && m_bcnt[u] < unit_cnt_max(u)) m_bcnt[u]++;
        end
    endtask

    task automatic check_all(input string tag);
        for (int u = 0; u < NU; u++) begin
            stage_t e;
            e = sb[u][sb[u].size() - 1];
            check($sformatf("%s u%0d valid", tag, u), 128'(o_valid[u]), 128'(e.valid));
            check($sformatf("%s u%0d ctrl", tag, u), 128'(o_ctrl[u]), 128'(e.ctrl));
            check($sformatf("%s u%0d data", tag, u), o_data[u], e.data);
            check($sformatf("%s u%0d stall_cnt", tag, u), 128'(o_scnt[u]), 128'(m_scnt[u]));
            check($sformatf("%s u%0d bubble_cnt", tag, u), 128'(o_bcnt[u]), 128'(m_bcnt[u]));
        end
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic en, input logic st, input logic bu, input logic fl,
                         input logic vi, input logic [7:0] c, input logic [127:0] d);
        enable   = en;
        stall    = st;
        bubble   = bu;
        flush    = fl;
        valid_in = vi;
        ctrl_in  = c;
        data_in  = d;
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        check_all(tag);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 128'd0);
        reset = 1'b1;
        #2;
        model_reset();
        check_all("reset_async");
        apply_reset("reset");

        // Vector table; fixed expectations are for the DEPTH=1 instance
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 32'h2001_0004, 1'b1, 8'hA5, 32'h2001_0004};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 32'h1111_2222, 1'b1, 8'h3C, 32'h1111_2222};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 32'hDEAD_0001, 1'b1, 8'h3C, 32'h1111_2222};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 32'hBEEF_0002, 1'b0, 8'h00, 32'h0000_0000};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 32'h0000_1234, 1'b0, 8'h00, 32'h0000_0000};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 32'hCAFE_F00D, 1'b1, 8'h81, 32'hCAFE_F00D};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h99, 32'h0BAD_0BAD, 1'b1, 8'h81, 32'hCAFE_F00D};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h42, 32'h0000_ABCD, 1'b0, 8'h00, 32'h0000_0000};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42, 32'h0000_ABCD, 1'b1, 8'h42, 32'h0000_ABCD};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h13, 32'h1313_1313, 1'b1, 8'h42, 32'h0000_ABCD};
        vt[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 32'h1010_1010, 1'b1, 8'h42, 32'h0000_ABCD};
        vt[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h24, 32'h2424_2424, 1'b0, 8'h00, 32'h0000_0000};

        for (int i = 0; i < 12; i++) begin
            logic [31:0] c3;
            c3 = vt[i].ch3;
            drive(vt[i].en, vt[i].st, vt[i].bu, vt[i].fl, vt[i].vi, vt[i].ctrl,
                  {c3, ~c3, c3 ^ 32'h5A5A_5A5A, 32'(i)});
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d d1 valid", i), 128'(o_valid[0]), 128'(vt[i].ev));
            check($sformatf("vec%0d d1 ctrl", i), 128'(o_ctrl[0]), 128'(vt[i].ectrl));
            check($sformatf("vec%0d d1 ch3", i), 128'(o_data[0][CH_INSTRUC*32 +: 32]), 128'(vt[i].ech3));
        end

        // Words 1,2,3 then a two-cycle stall on DEPTH=3
        apply_reset("t2_reset");
        for (int w = 1; w <= 3; w++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'(w), word(w));
            step($sformatf("t2_load%0d", w));
        end
        check("t2 d3 word1 valid", 128'(o_valid[3]), 128'd1);
        check("t2 d3 word1 data", o_data[3], word(1));
        for (int s = 0; s < 2; s++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4, word(4));
            step($sformatf("t2_stall%0d", s));
            check($sformatf("t2 d3 held word1 s%0d", s), o_data[3], word(1));
        end
        check("t2 d3 stall_cnt", 128'(o_scnt[3]), 128'(exp_cnt(2)));
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, word(4));
        step("t2_release");
        check("t2 d3 word2 after release", o_data[3], word(2));
        check("t2 d3 ctrl word2", 128'(o_ctrl[3]), 128'd2);

        // Bubble through DEPTH=2 with and without control zeroing
        apply_reset("t3_reset");
        for (int w = 10; w < 12; w++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, word(w));
            step($sformatf("t3_fill%0d", w));
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, word(99));
        step("t3_bubble");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, word(12));
        step("t3_after");
        check("t3 zero valid", 128'(o_valid[1]), 128'd0);
        check("t3 zero ctrl", 128'(o_ctrl[1]), 128'd0);
        check("t3 zero data", o_data[1], 128'd0);
        check("t3 zero bubble_cnt", 128'(o_bcnt[1]), 128'(exp_cnt(1)));
        check("t3 pass valid", 128'(o_valid[2]), 128'd0);
        check("t3 pass ctrl", 128'(o_ctrl[2]), 128'hFF);
        check("t3 pass data", o_data[2], 128'd0);

        // Flush beats stall on a full DEPTH=3 chain
        apply_reset("t4_reset");
        for (int w = 20; w < 23; w++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5C, word(w));
            step($sformatf("t4_fill%0d", w));
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5C, word(23));
        step("t4_stall");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5C, word(23));
        step("t4_flush");
        check("t4 flush valid", 128'(o_valid[3]), 128'd0);
        check("t4 flush data", o_data[3], 128'd0);
        check("t4 stall_cnt unchanged", 128'(o_scnt[3]), 128'(exp_cnt(1)));
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 128'd0);
            step($sformatf("t4_drain%0d", c));
            check($sformatf("t4 empty valid c%0d", c), 128'(o_valid[3]), 128'd0);
            check($sformatf("t4 empty ctrl c%0d", c), 128'(o_ctrl[3]), 128'd0);
        end

        // Enable low freezes everything while stall/bubble toggle
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h66, word(30));
        step("t5_load");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h67, word(31));
        step("t5_bubble");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h68, word(32));
        step("t5_stall");
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, c[0], ~c[0], 1'b0, 1'b1, 8'(8'h70 + c), word(40 + c));
            step($sformatf("t5_frozen%0d", c));
        end

        // Async reset between edges while full
        for (int w = 50; w < 53; w++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hE1, word(w));
            step($sformatf("t6_fill%0d", w));
        end
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("t6_midcycle_reset");
        check("t6 d3 valid before edge", 128'(o_valid[3]), 128'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // CNT_W=2 counter saturates at 3 after 5 stalls
        for (int s = 0; s < 5; s++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hE2, word(60));
            step($sformatf("t6_sat%0d", s));
        end
        check("t6 sat stall_cnt", 128'(o_scnt[4]), 128'(exp_cnt(3)));
        check("t6 wide stall_cnt", 128'(o_scnt[3]), 128'(exp_cnt(5)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_gen.md
Name: pipe_stage_gen

Overview:
- Parametrised successor to the fixed inter-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB class) of the DLX core.
- Carries a valid bit, a control field and NUM_CH data buses through DEPTH register stages.
- Supports global enable, stall (hold), bubble insertion at entry, and full flush.
- Optional saturating stall/bubble statistics counters, readable over the UART debug path.

Parameters:
DATA_W, 32, width of each data channel
NUM_CH, 4, number of data channels (bus_a, bus_b, immed, instruc for ID/EX use)
CTRL_W, 8, control field width (EX/M/WB control concatenated)
DEPTH, 1, number of register stages; legal range 1..4
ZERO_CTRL_ON_BUBBLE, 1, 1: bubble forces control to 0; 0: control passes through on bubble
CNT_W, 16, statistics counter width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  global step enable (debug single-step); 0 holds everything
stall  in  1  hold all stages this cycle
bubble  in  1  insert a bubble at stage 0; downstream stages advance
flush  in  1  clear every stage
valid_in  in  1  entry instruction valid
ctrl_in  in  CTRL_W  entry control field
data_in  in  NUM_CH*DATA_W  entry data; channel k occupies bits [k*DATA_W +: DATA_W]
valid_out  out  1  last-stage valid
ctrl_out  out  CTRL_W  last-stage control
data_out  out  NUM_CH*DATA_W  last-stage data
stall_cnt  out  CNT_W  cycles with enable&&stall&&!flush
bubble_cnt  out  CNT_W  bubbles inserted (enable&&bubble&&!stall&&!flush)

Behaviour:
- Reset (async, any time, including mid-stall or mid-flush): every stage valid=0, ctrl=0, data=0. Counters=0. All outputs read 0 immediately, without waiting for a clock edge.
- Outputs are driven directly from the last stage register; there is no combinational path from input to output.
- Latency is DEPTH cycles from a capture at stage 0 to its appearance on the outputs.
- Per rising edge, priority order:
  1. enable=0: every register holds, counters included.
  2. flush=1: every stage gets valid=0, ctrl=0, data=0. Flush overrides stall and bubble.
  3. stall=1: every stage holds.
  4. bubble=1, or valid_in=0: stage 0 gets valid=0 and data=0. Control is 0 if ZERO_CTRL_ON_BUBBLE=1, otherwise ctrl_in. Stages 1..DEPTH-1 shift normally.
  5. Otherwise: stage 0 captures valid_in, ctrl_in and data_in; stage i captures stage i-1.
- Simultaneous stall and bubble: stall wins; no bubble is inserted and bubble_cnt does not increment.
- Bubble when DEPTH=1: the outputs show the bubble on the next cycle.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- DEPTH outside 1..4 is rejected at elaboration with a generate-time error.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined: stall_cnt and bubble_cnt are implemented as specified above.
- Undefined: both ports remain and are tied to constant 0; no counter flops are generated.

Decomposition:
- Shared package pipe_pkg holds:
  - ID/EX control field offsets (EX_CTRL_LSB, M_CTRL_LSB, WB_CTRL_LSB)
  - channel index constants (CH_BUS_A=0, CH_BUS_B=1, CH_IMMED=2, CH_INSTRUC=3)
  - MAX_DEPTH=4
- One natural sub-module, pipe_stage_cell: a single stage with hold, clear and load inputs. The top instantiates DEPTH of them in a generate loop; priority decoding and the counters stay in the top.

Test Plan:
1. DEPTH=1, enable=1, valid_in=1, ctrl_in=8'hA5, ch3=32'h2001_0004 -> next edge: valid_out=1, ctrl_out=8'hA5, ch3 out=32'h2001_0004.
2. DEPTH=3, drive 3 consecutive valid words 1, 2, 3, then stall for 2 cycles -> outputs show 1 at cycle 3; hold through both stall cycles; 2 appears once the stall is released; stall_cnt=2.
3. DEPTH=2, bubble=1 for 1 cycle with ctrl_in=8'hFF, ZERO_CTRL_ON_BUBBLE=1 -> 2 cycles later valid_out=0, ctrl_out=0, data_out=0; bubble_cnt=1. Repeat with ZERO_CTRL_ON_BUBBLE=0 -> ctrl_out=8'hFF, data_out=0.
4. DEPTH=3, pipeline full, flush and stall both asserted -> next edge: all stages empty (valid_out=0 with zero payload for 3 cycles with no new input); stall_cnt unchanged.
5. enable=0 for 5 cycles while stall=1 and bubble=1 toggle -> all outputs and counters frozen.
6. Reset pulse asserted between clock edges while full -> outputs 0 before the next edge. CNT_W=2 with 5 stall cycles -> stall_cnt saturates at 3.
